// File: rtl/montgomery_exp_ctrl_pkg.sv
// Shared constants and FSM state type for the Montgomery exponentiation sequencer.
// Package name montexp_pkg is referenced by the control block and its multiplier interface.
package montexp_pkg;

    localparam int NBITS  = 512;
    localparam int WIDTH  = NBITS + 2;
    localparam int ELEN_W = 10;
    localparam int IDX_W  = $clog2(NBITS);

    localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
    localparam logic [ELEN_W-1:0] ELEN_MAX = ELEN_W'(NBITS);

    typedef enum logic [3:0] {
        IDLE,
        SQR_ISSUE,
        SQR_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        NEXT,
        CONV_ISSUE,
        CONV_WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/montgomery_exp_ctrl_if.sv
// Handshake bundle between the exponentiation sequencer and the shared Montgomery multiplier.
// master = sequencer side, slave = multiplier side.
interface montgomery_exp_ctrl_if;
    import montexp_pkg::*;

    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_m;
    logic [NBITS-1:0] mm_result;
    logic             mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_result, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_result, mm_done
    );

endinterface

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M on a shared Montgomery multiplier.
// Optional macro MONTEXP_OPCOUNT_EN adds an op_count output counting multiplier issues per job.
module montgomery_exp_ctrl
    import montexp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_rm,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [NBITS-1:0]     in_e,
    input  logic [ELEN_W-1:0]    in_elen,
    output logic                 busy,
    output logic                 done,
    output logic [NBITS-1:0]     result,
`ifdef MONTEXP_OPCOUNT_EN
    output logic [15:0]          op_count,
`endif
    montgomery_exp_ctrl_if.master mm
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    x_q, x_d;
    logic [WIDTH-1:0]    m_q, m_d;
    logic [NBITS-1:0]    e_q, e_d;
    logic [ELEN_W-1:0]   idx_q, idx_d;
    logic                busy_q, busy_d;
    logic [NBITS-1:0]    result_q, result_d;
    logic [ELEN_W-1:0]   elen_sat;
    logic                accept;
    logic                issue;

    assign elen_sat = (in_elen > ELEN_MAX) ? ELEN_MAX : in_elen;
    assign accept   = (state_q == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            x_q      <= '0;
            m_q      <= '0;
            e_q      <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            m_q      <= m_d;
            e_q      <= e_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        x_d      = x_q;
        m_d      = m_q;
        e_d      = e_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        result_d = result_q;
        issue    = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d    = in_x;
                    acc_d  = in_rm;
                    m_d    = in_m;
                    e_d    = in_e;
                    idx_d  = elen_sat - ELEN_W'(1);
                    busy_d = 1'b1;
                    state_d = (elen_sat == '0) ? CONV_ISSUE : SQR_ISSUE;
                end
            end
            SQR_ISSUE: begin
                issue   = 1'b1;
                state_d = SQR_WAIT;
            end
            SQR_WAIT: begin
                if (mm.mm_done) begin
                    acc_d   = WIDTH'(mm.mm_result);
                    state_d = e_q[idx_q[IDX_W-1:0]] ? MUL_ISSUE : NEXT;
                end
            end
            MUL_ISSUE: begin
                issue   = 1'b1;
                state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mm.mm_done) begin
                    acc_d   = WIDTH'(mm.mm_result);
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == '0) begin
                    state_d = CONV_ISSUE;
                end else begin
                    idx_d   = idx_q - ELEN_W'(1);
                    state_d = SQR_ISSUE;
                end
            end
            CONV_ISSUE: begin
                issue   = 1'b1;
                state_d = CONV_WAIT;
            end
            CONV_WAIT: begin
                if (mm.mm_done) begin
                    result_d = mm.mm_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are decoded from state so they hold from the issue cycle through the whole wait.
    always_comb begin
        mm.mm_a = '0;
        mm.mm_b = '0;
        case (state_q)
            SQR_ISSUE, SQR_WAIT: begin
                mm.mm_a = acc_q;
                mm.mm_b = acc_q;
            end
            MUL_ISSUE, MUL_WAIT: begin
                mm.mm_a = acc_q;
                mm.mm_b = x_q;
            end
            CONV_ISSUE, CONV_WAIT: begin
                mm.mm_a = acc_q;
                mm.mm_b = ONE_W;
            end
            default: ;
        endcase
    end

    assign mm.mm_start = issue;
    assign mm.mm_m     = m_q;
    assign busy        = busy_q;
    assign result      = result_q;

`ifdef MONTEXP_OPCOUNT_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q <= '0;
        end else if (accept) begin
            op_cnt_q <= '0;
        end else if (issue) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_count = op_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Self-checking bench: behavioural Montgomery multiplier with random latency and spurious done
// pulses, results compared against a plain integer modular exponentiation.
module tb_montgomery_exp_ctrl;
    import montexp_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  in_x = '0;
    logic [WIDTH-1:0]  in_rm = '0;
    logic [WIDTH-1:0]  in_m = '0;
    logic [NBITS-1:0]  in_e = '0;
    logic [ELEN_W-1:0] in_elen = '0;
    logic              busy;
    logic              done;
    logic [NBITS-1:0]  result;
`ifdef MONTEXP_OPCOUNT_EN
    logic [15:0]       op_count;
`endif

    montgomery_exp_ctrl_if mm_bus();

    montgomery_exp_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_x    (in_x),
        .in_rm   (in_rm),
        .in_m    (in_m),
        .in_e    (in_e),
        .in_elen (in_elen),
        .busy    (busy),
        .done    (done),
        .result  (result),
`ifdef MONTEXP_OPCOUNT_EN
        .op_count(op_count),
`endif
        .mm      (mm_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // a*b*2^-512 mod m by bitwise REDC
    function automatic logic [NBITS-1:0] mont_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] m);
        logic [2*WIDTH-1:0] t;
        logic [2*WIDTH-1:0] mw;
        mw = (2*WIDTH)'(m);
        t  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        for (int i = 0; i < NBITS; i++) begin
            if (t[0]) t = t + mw;
            t = t >> 1;
        end
        if (t >= mw) t = t - mw;
        return t[NBITS-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] to_mont(input longint unsigned v, input longint unsigned m);
        logic [2*WIDTH-1:0] w;
        w = (2*WIDTH)'(v) << NBITS;
        w = w % (2*WIDTH)'(m);
        return w[WIDTH-1:0];
    endfunction

    function automatic longint unsigned modexp(input longint unsigned x, input logic [NBITS-1:0] e,
                                               input int elen, input longint unsigned m);
        longint unsigned r, b;
        r = 1 % m;
        b = x % m;
        for (int i = 0; i < elen; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r;
    endfunction

    // Behavioural multiplier, driven on the falling edge
    int unsigned      lat_min = 2;
    int unsigned      lat_max = 3;
    bit               spur_en = 1'b0;
    int unsigned      mcnt = 0;
    int unsigned      starts = 0;
    int unsigned      unstable = 0;
    int unsigned      done_seen = 0;
    logic [WIDTH-1:0] cap_a, cap_b, cap_m;
    logic [NBITS-1:0] pend;

    always @(negedge clk) begin
        mm_bus.mm_done = 1'b0;
        if (done) done_seen++;
        if (mm_bus.mm_start) begin
            starts++;
            cap_a = mm_bus.mm_a;
            cap_b = mm_bus.mm_b;
            cap_m = mm_bus.mm_m;
            pend  = mont_mul(cap_a, cap_b, cap_m);
            mcnt  = $urandom_range(lat_max - 1, lat_min - 1);
        end else if (mcnt > 0) begin
            if (mm_bus.mm_a !== cap_a || mm_bus.mm_b !== cap_b || mm_bus.mm_m !== cap_m) unstable++;
            mcnt--;
            if (mcnt == 0) begin
                mm_bus.mm_result = pend;
                mm_bus.mm_done   = 1'b1;
            end
        end else if (spur_en && $urandom_range(15, 0) == 0) begin
            mm_bus.mm_result = NBITS'($urandom);
            mm_bus.mm_done   = 1'b1;
        end
    end

    function automatic logic [NBITS-1:0] rand_e();
        logic [NBITS-1:0] v;
        for (int i = 0; i < NBITS / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_job(input longint unsigned xp, input longint unsigned m,
                            input logic [NBITS-1:0] e, input int elen);
        in_x    = to_mont(xp % m, m);
        in_rm   = to_mont(1, m);
        in_m    = WIDTH'(m);
        in_e    = e;
        in_elen = ELEN_W'(elen);
    endtask

    task automatic run_job(input string tag, input longint unsigned xp, input longint unsigned m,
                           input logic [NBITS-1:0] e, input int elen, input bit poke_mid, input bit poke_done);
        int elen_eff, exp_ops, limit, cyc;
        longint unsigned exp_res;
        int unsigned s0, u0, d0;
        elen_eff = (elen > NBITS) ? NBITS : elen;
        exp_res  = modexp(xp, e, elen_eff, m);
        exp_ops  = elen_eff + 1;
        for (int i = 0; i < elen_eff; i++) exp_ops += int'(e[i]);
        limit = exp_ops * (int'(lat_max) + 4) + 50;
        load_job(xp, m, e, elen);
        s0 = starts; u0 = unstable; d0 = done_seen;
        pulse_start();
        in_x = to_mont(longint'($urandom_range(12, 1)), m);
        in_e = rand_e();
        in_elen = ELEN_W'($urandom_range(20, 0));
        check({tag, "_busy_run"}, WIDTH'(busy), WIDTH'(1));
        if (poke_mid) begin
            repeat (3) @(posedge clk);
            pulse_start();
        end
        cyc = 0;
        @(negedge clk);
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_timeout"}, WIDTH'(cyc >= limit), WIDTH'(0));
        check({tag, "_result"}, WIDTH'(result), WIDTH'(exp_res));
        if (poke_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_busy_after"}, WIDTH'(busy), WIDTH'(0));
        @(negedge clk);
        check({tag, "_ops"}, WIDTH'(starts - s0), WIDTH'(exp_ops));
        check({tag, "_stable"}, WIDTH'(unstable - u0), WIDTH'(0));
        check({tag, "_done_pulses"}, WIDTH'(done_seen - d0), WIDTH'(1));
`ifdef MONTEXP_OPCOUNT_EN
        check({tag, "_op_count"}, WIDTH'(op_count), WIDTH'(exp_ops));
`endif
    endtask

    initial begin
        logic [NBITS-1:0] ones;
        longint unsigned  m;
        int unsigned      s1;
        int               cyc;
        ones = '1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", WIDTH'(busy), WIDTH'(0));
        check("rst_done", WIDTH'(done), WIDTH'(0));
        check("rst_result", WIDTH'(result), WIDTH'(0));
        check("rst_mm_start", WIDTH'(mm_bus.mm_start), WIDTH'(0));
        check("rst_mm_a", mm_bus.mm_a, WIDTH'(0));
        check("rst_mm_b", mm_bus.mm_b, WIDTH'(0));
        check("rst_mm_m", mm_bus.mm_m, WIDTH'(0));

        run_job("e5", 2, 13, NBITS'(5), 3, 1'b0, 1'b1);
        check("e5_value", WIDTH'(result), WIDTH'(6));
        run_job("elen0", 7, 13, rand_e(), 0, 1'b0, 1'b0);
        run_job("ones512", 3, 13, ones, 512, 1'b0, 1'b0);
        run_job("sat700", 5, 1000003, rand_e(), 700, 1'b0, 1'b0);

        // start mid-run, then reset during the first multiply wait
        lat_min = 20; lat_max = 30;
        load_job(2, 13, NBITS'(5), 3);
        s1 = starts;
        pulse_start();
        repeat (3) @(posedge clk);
        in_x = to_mont(9, 13);
        pulse_start();
        cyc = 0;
        while (starts - s1 < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_mul", WIDTH'(starts - s1), WIDTH'(2));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", WIDTH'(busy), WIDTH'(0));
        check("abort_done", WIDTH'(done), WIDTH'(0));
        check("abort_result", WIDTH'(result), WIDTH'(0));
        check("abort_mm_start", WIDTH'(mm_bus.mm_start), WIDTH'(0));
        s1 = starts;
        cyc = 0;
        while (mcnt != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("stale_delivered", WIDTH'(mcnt), WIDTH'(0));
        repeat (4) @(negedge clk);
        check("stale_busy", WIDTH'(busy), WIDTH'(0));
        check("stale_no_issue", WIDTH'(starts - s1), WIDTH'(0));
        check("stale_result", WIDTH'(result), WIDTH'(0));
        run_job("after_abort", 2, 13, NBITS'(5), 3, 1'b0, 1'b0);

        // long random latencies with spurious done pulses
        spur_en = 1'b1;
        lat_min = 2; lat_max = 600;
        for (int j = 0; j < 3; j++) begin
            m = longint'($urandom_range(32'h7fff_ffff, 3)) | 1;
            run_job($sformatf("slow%0d", j), longint'($urandom) % m, m, rand_e(),
                    int'($urandom_range(6, 1)), j == 0, 1'b0);
        end
        lat_max = 40;
        for (int j = 0; j < 6; j++) begin
            m = longint'($urandom_range(32'h7fff_ffff, 3)) | 1;
            run_job($sformatf("rnd%0d", j), longint'($urandom) % m, m, rand_e(),
                    int'($urandom_range(40, 0)), 1'b1, j[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
